// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;

  // Bit counter width: $clog2 of the operand width, never below one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result handshake between a datapath and serial_add_ctrl.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] x_val;
  logic [WIDTH-1:0] y_val;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output start, x_val, y_val, c_in, sub,
                  input  busy, done, sum, c_out);
  modport slave  (input  start, x_val, y_val, c_in, sub,
                  output busy, done, sum, c_out);
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder cell: parity sum, majority carry. Purely combinational.
module fa_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_c;
  assign o_c = (i_x & i_y) | (i_x & i_c) | (i_y & i_c);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one fa_cell over WIDTH bits, LSB first.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int             CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LP_TERM = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, r_y, r_psum, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_done;
  logic             w_s, w_c, w_accept, w_last;
  logic [WIDTH-1:0] w_y_ld, w_psum_nxt;
  logic             w_cin_ld;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as X + ~Y + 1; c_in is ignored in that mode.
  assign w_y_ld   = bus.sub ? ~bus.y_val : bus.y_val;
  assign w_cin_ld = bus.sub ? 1'b1 : bus.c_in;
`else
  logic w_unused_sub;
  assign w_unused_sub = bus.sub;
  assign w_y_ld       = bus.y_val;
  assign w_cin_ld     = bus.c_in;
`endif

  fa_cell u_fa (
    .i_x (r_x[0]),
    .i_y (r_y[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_last     = (r_cnt == LP_TERM);
  assign w_psum_nxt = {w_s, r_psum[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, leave RUN on the edge handling the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then shift one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x     <= bus.x_val;
        r_y     <= w_y_ld;
        r_carry <= w_cin_ld;
        r_cnt   <= '0;
        r_psum  <= '0;
      end else if (r_state == RUN) begin
        r_psum  <= w_psum_nxt;
        r_x     <= r_x >> 1;
        r_y     <= r_y >> 1;
        r_carry <= w_c;
        if (w_last) begin
          // Results only move here so they stay stable through RUN.
          r_sum  <= w_psum_nxt;
          r_cout <= w_c;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy  = (r_state == RUN);
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.c_out = r_cout;
endmodule
